// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared CPU-side definitions for the data memory responder:
//   - DATA_W / ADDR_W : 16-bit data and word-address widths
//   - LATENCY_MIN/MAX : legal bounds of the responder's WAIT latency
//   - CNT_W           : width of the WAIT down-counter
//   - state_t         : responder FSM state encoding (2 bits)
//   - latency_load()  : counter reload value for a given latency, clamped
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter is loaded with LATENCY-1 so that WAIT spans LATENCY cycles.
    // Out-of-range latencies are clamped into the legal window.
    function automatic logic [CNT_W-1:0] latency_load(input int latency);
        int lat;
        lat = latency;
        if (lat < LATENCY_MIN) lat = LATENCY_MIN;
        if (lat > LATENCY_MAX) lat = LATENCY_MAX;
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port data storage: synchronous write, synchronous (registered) read.
// Contents are never reset.
// Ports:
//   clk   - clock
//   en    - access enable (read or write this edge)
//   we    - 1 = write wdata to mem[addr], 0 = read mem[addr] into rdata
//   addr  - word index
//   wdata - write data
//   rdata - registered read data, updated on enabled accesses only
// -----------------------------------------------------------------------------
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    // Read-first: rdata on a write edge carries the old word; the responder
    // never uses rdata after a write, so this costs nothing.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// CPU data-memory responder: accepts one request at a time in IDLE, spends
// LATENCY cycles in WAIT, performs the access on the WAIT->RESP edge, then
// presents a response (read data or write acknowledge) held until resp_ready.
// Optional feature: define DMEM_RANGE_CHECK_EN to flag req_addr >= DEPTH as
// an error (write suppressed, read returns 0, resp_err = 1). Without it the
// address wraps to its low clog2(DEPTH) bits and resp_err is tied to 0.
// Ports:
//   clk, rst (synchronous, active-low)
//   req_valid, req_we, req_addr, req_wdata, req_ready   - request channel
//   resp_valid, resp_ready, data_mem_to_cpu, resp_err   - response channel
// Parameters: DEPTH (words, default 256), LATENCY (1..15, default 2).
// -----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] data_mem_to_cpu,
    output logic              resp_err
);

    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = latency_load(LATENCY);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              we_reg;
    logic [IDX_W-1:0]  addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              err_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic              resp_err_reg;
    logic [DATA_W-1:0] rdata_out_reg;

    logic              addr_err;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_RANGE_CHECK_EN
    assign addr_err = (32'(req_addr) >= 32'(DEPTH));
`else
    // Upper address bits are deliberately dropped (aliasing).
    logic addr_hi_unused;
    assign addr_hi_unused = ^req_addr;
    assign addr_err       = 1'b0;
`endif

    // The array access fires during the last WAIT cycle so it lands on the
    // WAIT->RESP edge. Gating with rst keeps an aborted write out of memory.
    assign mem_en = rst && (state_reg == WAIT) && (cnt_reg == '0);
    assign mem_we = we_reg && !err_reg;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_dmem_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    // RESP has two phases: the first cycle is the array's registered-read
    // cycle (resp_valid still low); on the next edge the outputs are loaded
    // and resp_valid rises, LATENCY+1 edges after the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            err_reg        <= 1'b0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            rdata_out_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        we_reg        <= req_we;
                        addr_reg      <= req_addr[IDX_W-1:0];
                        wdata_reg     <= req_wdata;
                        err_reg       <= addr_err;
                        cnt_reg       <= CNT_LOAD;
                        req_ready_reg <= 1'b0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (!resp_valid_reg) begin
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= err_reg;
                        // Writes leave the last read value in place.
                        if (!we_reg) begin
                            rdata_out_reg <= err_reg ? '0 : mem_rdata;
                        end
                    end else if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        resp_err_reg   <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_reg;
    assign resp_valid      = resp_valid_reg;
    assign resp_err        = resp_err_reg;
    assign data_mem_to_cpu = rdata_out_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Three responders (LATENCY 2, 1, 15; DEPTH 256) driven by directed steps.
// Expectations follow DMEM_RANGE_CHECK_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid  [NI];
    logic        req_we     [NI];
    logic [15:0] req_addr   [NI];
    logic [15:0] req_wdata  [NI];
    logic        req_ready  [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [15:0] rdata      [NI];
    logic        resp_err   [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            data_mem_responder #(
                .DEPTH   (256),
                .LATENCY ((gi == 0) ? 2 : (gi == 1) ? 1 : 15)
            ) dut (
                .clk             (clk),
                .rst             (rst),
                .req_valid       (req_valid[gi]),
                .req_we          (req_we[gi]),
                .req_addr        (req_addr[gi]),
                .req_wdata       (req_wdata[gi]),
                .req_ready       (req_ready[gi]),
                .resp_valid      (resp_valid[gi]),
                .resp_ready      (resp_ready[gi]),
                .data_mem_to_cpu (rdata[gi]),
                .resp_err        (resp_err[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance i. lat = edges from the accepting
    // edge until resp_valid is seen. With disturb set, req_* keep changing
    // (a write of 16'hDEAD to addr 3) during the first WAIT cycle.
    task automatic do_req(input int i, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input bit disturb,
                          output int lat, output logic [15:0] data, output logic err);
        int n;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_wait", 32'(n < 50), 1);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        @(posedge clk); #1;
        if (disturb) begin
            req_we[i]    = 1'b1;
            req_addr[i]  = 16'd3;
            req_wdata[i] = 16'hDEAD;
        end else begin
            req_valid[i] = 1'b0;
        end
        lat = 0;
        while (resp_valid[i] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) req_valid[i] = 1'b0;
        end
        check("resp_valid_wait", 32'(lat < 40), 1);
        data = rdata[i];
        err  = resp_err[i];
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
        $display("txn inst=%0d we=%0d addr=%0d wdata=%h -> lat=%0d data=%h err=%0d",
                 i, we, addr, wdata, lat, data, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] d;
        logic        e;
        logic [15:0] d0;
        bit          stable;
        int          n;

        for (int i = 0; i < NI; i++) begin
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_addr[i]   = 16'd0;
            req_wdata[i]  = 16'd0;
            resp_ready[i] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        for (int i = 0; i < NI; i++) begin
            check("rst_req_ready",  32'(req_ready[i]),  1);
            check("rst_resp_valid", 32'(resp_valid[i]), 0);
            check("rst_resp_err",   32'(resp_err[i]),   0);
            check("rst_data",       32'(rdata[i]),      0);
        end

        // Write then read, LATENCY = 2
        do_req(0, 1'b1, 16'd3, 16'h1234, 1'b0, lat, d, e);
        check("wr3_lat", 32'(lat), 3);
        check("wr3_err", 32'(e), 0);
        do_req(0, 1'b0, 16'd3, 16'h0000, 1'b0, lat, d, e);
        check("rd3_lat", 32'(lat), 3);
        check("rd3_data", 32'(d), 32'h1234);

        // A write leaves the last read value on data_mem_to_cpu
        do_req(0, 1'b1, 16'd9, 16'h0BAD, 1'b0, lat, d, e);
        check("wr9_keeps_data", 32'(d), 32'h1234);

        // Reset mid-WAIT aborts a write of BEEF to 5
        do_req(0, 1'b1, 16'd5, 16'h5555, 1'b0, lat, d, e);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'd5; req_wdata[0] = 16'hBEEF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("abort_req_ready",  32'(req_ready[0]),  1);
        check("abort_resp_valid", 32'(resp_valid[0]), 0);
        check("abort_data",       32'(rdata[0]),      0);
        repeat (4) @(posedge clk);
        #1 check("abort_no_resp", 32'(resp_valid[0]), 0);
        do_req(0, 1'b0, 16'd5, 16'h0000, 1'b0, lat, d, e);
        check("abort_rd5_data", 32'(d), 32'h5555);

        // Backpressure: resp_ready held low for 5 cycles
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'd3;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("bp_resp_wait", 32'(n < 40), 1);
        d0 = rdata[0];
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp_valid[0] !== 1'b1 || rdata[0] !== d0 || req_ready[0] !== 1'b0) stable = 1'b0;
        end
        check("bp_data", 32'(d0), 32'h1234);
        check("bp_stable", 32'(stable), 1);
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        check("bp_release", 32'(resp_valid[0]), 0);
        $display("txn inst=0 backpressure read addr=3 data=%h stable=%0d", d0, stable);

        // req_* changes during WAIT are ignored
        do_req(0, 1'b0, 16'd9, 16'h0000, 1'b1, lat, d, e);
        check("dist_rd9_data", 32'(d), 32'h0BAD);
        do_req(0, 1'b0, 16'd3, 16'h0000, 1'b0, lat, d, e);
        check("dist_rd3_data", 32'(d), 32'h1234);

        // Address 300 vs DEPTH 256 (aliases to 44 without range check)
        do_req(0, 1'b1, 16'd44, 16'h4444, 1'b0, lat, d, e);
        do_req(0, 1'b1, 16'd300, 16'hAAAA, 1'b0, lat, d, e);
`ifdef DMEM_RANGE_CHECK_EN
        check("wr300_err", 32'(e), 1);
        check("wr300_lat", 32'(lat), 3);
        do_req(0, 1'b0, 16'd44, 16'h0000, 1'b0, lat, d, e);
        check("rd44_data", 32'(d), 32'h4444);
        do_req(0, 1'b0, 16'd300, 16'h0000, 1'b0, lat, d, e);
        check("rd300_data", 32'(d), 32'h0000);
        check("rd300_err", 32'(e), 1);
`else
        check("wr300_err", 32'(e), 0);
        do_req(0, 1'b0, 16'd44, 16'h0000, 1'b0, lat, d, e);
        check("rd44_data", 32'(d), 32'hAAAA);
        do_req(0, 1'b0, 16'd300, 16'h0000, 1'b0, lat, d, e);
        check("rd300_data", 32'(d), 32'hAAAA);
        check("rd300_err", 32'(e), 0);
`endif

        // Latency sweep
        do_req(1, 1'b1, 16'd7, 16'h0101, 1'b0, lat, d, e);
        check("l1_wr_lat", 32'(lat), 2);
        do_req(1, 1'b0, 16'd7, 16'h0000, 1'b0, lat, d, e);
        check("l1_rd_lat", 32'(lat), 2);
        check("l1_rd_data", 32'(d), 32'h0101);
        do_req(2, 1'b1, 16'd7, 16'h0F0F, 1'b0, lat, d, e);
        check("l15_wr_lat", 32'(lat), 16);
        do_req(2, 1'b0, 16'd7, 16'h0000, 1'b0, lat, d, e);
        check("l15_rd_lat", 32'(lat), 16);
        check("l15_rd_data", 32'(d), 32'h0F0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
